// File: rtl/de_decode_stage_pkg.sv
// Shared decode-stage definitions: op classes, RV32I opcodes, DE latch layout, immediate builder.
// No timing of its own; pure types and constants.
// No flow control here; consumers own backpressure.
package de_decode_stage_pkg;

    localparam int DBITS   = 32;
    localparam int REGS    = 32;
    localparam int SB_BITS = 2;

    localparam logic [3:0] OP_ALU_R   = 4'd0;
    localparam logic [3:0] OP_ALU_I   = 4'd1;
    localparam logic [3:0] OP_LOAD    = 4'd2;
    localparam logic [3:0] OP_STORE   = 4'd3;
    localparam logic [3:0] OP_BRANCH  = 4'd4;
    localparam logic [3:0] OP_JAL     = 4'd5;
    localparam logic [3:0] OP_JALR    = 4'd6;
    localparam logic [3:0] OP_LUI     = 4'd7;
    localparam logic [3:0] OP_AUIPC   = 4'd8;
    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic             valid;
        logic [3:0]       op;
        logic [3:0]       funct;
        logic [4:0]       rd;
        logic             wr_reg;
        logic [DBITS-1:0] rs1_val;
        logic [DBITS-1:0] rs2_val;
        logic [DBITS-1:0] imm;
        logic [DBITS-1:0] pc;
        logic [DBITS-1:0] pcplus;
        logic [DBITS-1:0] pred_pc;
        logic [DBITS-1:0] inst_count;
    } de_lat_t;

    function automatic logic [DBITS-1:0] gen_imm(input logic [3:0] op, input logic [31:0] inst);
        logic [DBITS-1:0] imm;
        case (op)
            OP_ALU_I, OP_LOAD, OP_JALR: imm = {{20{inst[31]}}, inst[31:20]};
            OP_STORE:                   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:                  imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:           imm = {inst[31:12], 12'h000};
            OP_JAL:                     imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default:                    imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/de_scoreboard.sv
// Per-register in-flight writer counters; busy reads discount a same-cycle WB when DE_WB_BYPASS_EN.
// Counters update one cycle after inc/dec strobes; reads are combinational.
// No backpressure: callers must never request an update that would drive a counter below zero.
module de_scoreboard
    import de_decode_stage_pkg::*;
#(
    parameter int REGS    = 32,
    parameter int SB_BITS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc_en,
    input  logic [$clog2(REGS)-1:0]  inc_idx,
    input  logic                     dec_flush_en,
    input  logic [$clog2(REGS)-1:0]  dec_flush_idx,
    input  logic                     dec_wb_en,
    input  logic [$clog2(REGS)-1:0]  dec_wb_idx,
    input  logic [$clog2(REGS)-1:0]  rd_a_idx,
    output logic                     rd_a_busy,
    input  logic [$clog2(REGS)-1:0]  rd_b_idx,
    output logic                     rd_b_busy,
    input  logic [$clog2(REGS)-1:0]  full_idx,
    output logic                     full
);
    localparam int IW = $clog2(REGS);
    localparam logic [SB_BITS-1:0] CNT_MAX = '1;

    logic [SB_BITS-1:0] cnt_q [REGS];
    logic [SB_BITS-1:0] cnt_d [REGS];
    logic               underflow;
    int                 sum;

    // Events on one register add algebraically, so issue+WB cancels and flush+WB subtracts two.
    always_comb begin
        underflow = 1'b0;
        sum       = 0;
        for (int i = 0; i < REGS; i++) begin
            sum = int'(cnt_q[i])
                + int'(inc_en && inc_idx == IW'(i))
                - int'(dec_flush_en && dec_flush_idx == IW'(i))
                - int'(dec_wb_en && dec_wb_idx == IW'(i));
            if (sum < 0) begin
                underflow = 1'b1;
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i]  = SB_BITS'(sum);
            end
        end
    end

    always_comb begin
`ifdef DE_WB_BYPASS_EN
        rd_a_busy = cnt_q[rd_a_idx] > SB_BITS'(dec_wb_en && dec_wb_idx == rd_a_idx);
        rd_b_busy = cnt_q[rd_b_idx] > SB_BITS'(dec_wb_en && dec_wb_idx == rd_b_idx);
`else
        rd_a_busy = cnt_q[rd_a_idx] != '0;
        rd_b_busy = cnt_q[rd_b_idx] != '0;
`endif
        full = cnt_q[full_idx] == CNT_MAX;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < REGS; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) assert (!underflow) else $error("de_scoreboard: in-flight counter underflow");
    end

endmodule

// File: rtl/de_decode_stage.sv
// RV32I decode + RF read + scoreboard issue into the DE latch; DE_WB_BYPASS_EN adds RF write-through.
// One cycle FE latch -> DE latch; flush on AGEX mispredict bubbles the latch and undoes its issue.
// RAW/WAW hazards insert a bubble and raise stall_to_fe so fetch holds its latch and PC.
module de_decode_stage
    import de_decode_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             fe_valid,
    input  logic [31:0]      fe_inst,
    input  logic [DBITS-1:0] fe_pc,
    input  logic [DBITS-1:0] fe_pcplus,
    input  logic [DBITS-1:0] fe_pred_pc,
    input  logic [DBITS-1:0] fe_inst_count,
    input  logic             br_mispred_agex,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic [DBITS-1:0] wb_data,
    output logic             stall_to_fe,
    output logic             de_valid,
    output logic [3:0]       de_op,
    output logic [3:0]       de_funct,
    output logic [4:0]       de_rd,
    output logic             de_wr_reg,
    output logic [DBITS-1:0] de_rs1_val,
    output logic [DBITS-1:0] de_rs2_val,
    output logic [DBITS-1:0] de_imm,
    output logic [DBITS-1:0] de_pc,
    output logic [DBITS-1:0] de_pcplus,
    output logic [DBITS-1:0] de_pred_pc,
    output logic [DBITS-1:0] de_inst_count
);
    logic [4:0]       rs1, rs2, rd;
    logic [3:0]       op;
    logic             uses_rs1, uses_rs2, wr_reg;
    logic             busy1, busy2, rd_full;
    logic             hz, issue, wb_wr;
    logic [DBITS-1:0] rs1_val, rs2_val;
    logic [DBITS-1:0] rf_q [REGS];
    logic [DBITS-1:0] rf_d [REGS];
    de_lat_t          de_q, de_d;

    assign rs1   = fe_inst[19:15];
    assign rs2   = fe_inst[24:20];
    assign rd    = fe_inst[11:7];
    assign wb_wr = wb_we & (wb_rd != 5'd0);

    always_comb begin
        op       = OP_ILLEGAL;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        wr_reg   = 1'b0;
        case (fe_inst[6:0])
            OPC_OP:     begin op = OP_ALU_R;  uses_rs1 = 1'b1; uses_rs2 = 1'b1; wr_reg = 1'b1; end
            OPC_OP_IMM: begin op = OP_ALU_I;  uses_rs1 = 1'b1; wr_reg = 1'b1; end
            OPC_LOAD:   begin op = OP_LOAD;   uses_rs1 = 1'b1; wr_reg = 1'b1; end
            OPC_STORE:  begin op = OP_STORE;  uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_BRANCH: begin op = OP_BRANCH; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_JAL:    begin op = OP_JAL;    wr_reg = 1'b1; end
            OPC_JALR:   begin op = OP_JALR;   uses_rs1 = 1'b1; wr_reg = 1'b1; end
            OPC_LUI:    begin op = OP_LUI;    wr_reg = 1'b1; end
            OPC_AUIPC:  begin op = OP_AUIPC;  wr_reg = 1'b1; end
            default:    ;
        endcase
        // x0 is never a producer or a hazard source
        uses_rs1 = uses_rs1 & (rs1 != 5'd0);
        uses_rs2 = uses_rs2 & (rs2 != 5'd0);
        wr_reg   = wr_reg & (rd != 5'd0);
    end

    always_comb begin
        rs1_val = rf_q[rs1];
        rs2_val = rf_q[rs2];
`ifdef DE_WB_BYPASS_EN
        if (wb_wr && wb_rd == rs1) rs1_val = wb_data;
        if (wb_wr && wb_rd == rs2) rs2_val = wb_data;
`else
`endif
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
    end

    de_scoreboard #(.REGS(REGS), .SB_BITS(SB_BITS)) u_sb (
        .clk           (clk),
        .reset         (reset),
        .inc_en        (issue & wr_reg),
        .inc_idx       (rd),
        .dec_flush_en  (br_mispred_agex & de_q.valid & de_q.wr_reg),
        .dec_flush_idx (de_q.rd),
        .dec_wb_en     (wb_wr),
        .dec_wb_idx    (wb_rd),
        .rd_a_idx      (rs1),
        .rd_a_busy     (busy1),
        .rd_b_idx      (rs2),
        .rd_b_busy     (busy2),
        .full_idx      (rd),
        .full          (rd_full)
    );

    assign hz          = fe_valid & ((uses_rs1 & busy1) | (uses_rs2 & busy2) | (wr_reg & rd_full));
    assign issue       = fe_valid & ~hz & ~br_mispred_agex;
    assign stall_to_fe = reset & hz & ~br_mispred_agex;

    always_comb begin
        de_d = '0;
        if (issue) begin
            de_d.valid      = 1'b1;
            de_d.op         = op;
            de_d.funct      = {fe_inst[30], fe_inst[14:12]};
            de_d.rd         = rd;
            de_d.wr_reg     = wr_reg;
            de_d.rs1_val    = rs1_val;
            de_d.rs2_val    = rs2_val;
            de_d.imm        = gen_imm(op, fe_inst);
            de_d.pc         = fe_pc;
            de_d.pcplus     = fe_pcplus;
            de_d.pred_pc    = fe_pred_pc;
            de_d.inst_count = fe_inst_count;
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_wr) rf_d[wb_rd] = wb_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            de_q <= '0;
            for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
        end else begin
            de_q <= de_d;
            rf_q <= rf_d;
        end
    end

    assign de_valid      = de_q.valid;
    assign de_op         = de_q.op;
    assign de_funct      = de_q.funct;
    assign de_rd         = de_q.rd;
    assign de_wr_reg     = de_q.wr_reg;
    assign de_rs1_val    = de_q.rs1_val;
    assign de_rs2_val    = de_q.rs2_val;
    assign de_imm        = de_q.imm;
    assign de_pc         = de_q.pc;
    assign de_pcplus     = de_q.pcplus;
    assign de_pred_pc    = de_q.pred_pc;
    assign de_inst_count = de_q.inst_count;

endmodule

// File: tb/tb_de_decode_stage.sv
// Bench for de_decode_stage: directed scenarios, then random traffic against a reference model.
// Build with or without DE_WB_BYPASS_EN, matching the RTL.
module tb_de_decode_stage;
    import de_decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset, fe_valid, br_mispred_agex, wb_we;
    logic [31:0] fe_inst, fe_pc, fe_pcplus, fe_pred_pc, fe_inst_count, wb_data;
    logic [4:0]  wb_rd;
    logic        stall_to_fe, de_valid, de_wr_reg;
    logic [3:0]  de_op, de_funct;
    logic [4:0]  de_rd;
    logic [31:0] de_rs1_val, de_rs2_val, de_imm, de_pc, de_pcplus, de_pred_pc, de_inst_count;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          sb_m [32];
    logic [31:0] rf_m [32];
    logic [238:0] m_lat;

    localparam logic [6:0] OPCS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                         7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

    always #5 clk = ~clk;

    de_decode_stage dut (
        .clk(clk), .reset(reset), .fe_valid(fe_valid), .fe_inst(fe_inst), .fe_pc(fe_pc),
        .fe_pcplus(fe_pcplus), .fe_pred_pc(fe_pred_pc), .fe_inst_count(fe_inst_count),
        .br_mispred_agex(br_mispred_agex), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_to_fe(stall_to_fe), .de_valid(de_valid), .de_op(de_op), .de_funct(de_funct),
        .de_rd(de_rd), .de_wr_reg(de_wr_reg), .de_rs1_val(de_rs1_val), .de_rs2_val(de_rs2_val),
        .de_imm(de_imm), .de_pc(de_pc), .de_pcplus(de_pcplus), .de_pred_pc(de_pred_pc),
        .de_inst_count(de_inst_count)
    );

    function automatic logic [238:0] obs();
        return {de_valid, de_op, de_funct, de_rd, de_wr_reg, de_rs1_val, de_rs2_val, de_imm,
                de_pc, de_pcplus, de_pred_pc, de_inst_count};
    endfunction

    function automatic logic [3:0] ref_op(input logic [31:0] ins);
        case (ins[6:0])
            7'h33: return OP_ALU_R;
            7'h13: return OP_ALU_I;
            7'h03: return OP_LOAD;
            7'h23: return OP_STORE;
            7'h63: return OP_BRANCH;
            7'h6F: return OP_JAL;
            7'h67: return OP_JALR;
            7'h37: return OP_LUI;
            7'h17: return OP_AUIPC;
            default: return OP_ILLEGAL;
        endcase
    endfunction

    // two's-complement value of an n-bit field
    function automatic int sx(input int val, input int bits);
        return (val >= (1 << (bits - 1))) ? val - (1 << bits) : val;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic [3:0] op;
        op = ref_op(ins);
        if (op inside {OP_ALU_I, OP_LOAD, OP_JALR}) return 32'(sx(int'(ins[31:20]), 12));
        if (op == OP_STORE)  return 32'(sx(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12));
        if (op == OP_BRANCH) return 32'(sx(int'(ins[31]) * 4096 + int'(ins[7]) * 2048
                                           + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2, 13));
        if (op inside {OP_LUI, OP_AUIPC}) return ins & 32'hFFFF_F000;
        if (op == OP_JAL) return 32'(sx(int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096
                                        + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2, 21));
        return 32'h0;
    endfunction

    function automatic bit ref_writes(input logic [31:0] ins);
        return !(ref_op(ins) inside {OP_STORE, OP_BRANCH, OP_ILLEGAL}) && ins[11:7] != 5'd0;
    endfunction

    function automatic int pend(input int r);
        int p;
        p = sb_m[r];
`ifdef DE_WB_BYPASS_EN
        if (wb_we && int'(wb_rd) == r && r != 0) p = p - 1;
`endif
        return p;
    endfunction

    function automatic logic [31:0] ref_read(input int r);
        if (r == 0) return 32'h0;
`ifdef DE_WB_BYPASS_EN
        if (wb_we && int'(wb_rd) == r) return wb_data;
`endif
        return rf_m[r];
    endfunction

    function automatic bit ref_hz();
        logic [3:0] op;
        bit u1, u2;
        int r1, r2, rd;
        op = ref_op(fe_inst);
        r1 = int'(fe_inst[19:15]);
        r2 = int'(fe_inst[24:20]);
        rd = int'(fe_inst[11:7]);
        u1 = !(op inside {OP_JAL, OP_LUI, OP_AUIPC, OP_ILLEGAL}) && r1 != 0;
        u2 = (op inside {OP_ALU_R, OP_STORE, OP_BRANCH}) && r2 != 0;
        return fe_valid && ((u1 && pend(r1) > 0) || (u2 && pend(r2) > 0)
                            || (ref_writes(fe_inst) && sb_m[rd] >= 3));
    endfunction

    function automatic bit exp_stall();
        return reset && ref_hz() && !br_mispred_agex;
    endfunction

    // advance one clock, updating the model from the inputs held across the edge
    task automatic tick();
        bit hz, wr;
        logic [31:0] v1, v2;
        logic [238:0] nxt;
        hz  = ref_hz();
        wr  = ref_writes(fe_inst);
        v1  = ref_read(int'(fe_inst[19:15]));
        v2  = ref_read(int'(fe_inst[24:20]));
        nxt = {1'b1, ref_op(fe_inst), fe_inst[30], fe_inst[14:12], fe_inst[11:7], wr, v1, v2,
               ref_imm(fe_inst), fe_pc, fe_pcplus, fe_pred_pc, fe_inst_count};
        @(posedge clk);
        if (!reset) begin
            m_lat = '0;
            for (int i = 0; i < 32; i++) begin sb_m[i] = 0; rf_m[i] = '0; end
        end else begin
            if (br_mispred_agex) begin
                if (m_lat[238] && m_lat[224]) sb_m[m_lat[229:225]] -= 1;
                m_lat = '0;
            end else if (hz || !fe_valid) begin
                m_lat = '0;
            end else begin
                m_lat = nxt;
                if (wr) sb_m[fe_inst[11:7]] += 1;
            end
            if (wb_we && wb_rd != 5'd0) begin
                rf_m[wb_rd] = wb_data;
                sb_m[wb_rd] -= 1;
            end
        end
        #1;
    endtask

    task automatic set_fe(input logic [31:0] ins);
        fe_valid      = 1'b1;
        fe_inst       = ins;
        fe_pc         = $urandom & 32'hFFFF_FFFC;
        fe_pcplus     = fe_pc + 32'd4;
        fe_pred_pc    = $urandom;
        fe_inst_count = $urandom;
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0; br_mispred_agex = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        set_fe(32'hFFF1_0093);
        #1;
        n_checks++;
        if (stall_to_fe !== 1'b0) begin n_fail++; $display("FAIL reset_stall_pre: got %b want 0", stall_to_fe); end
        tick();
        tick();
        n_checks++;
        if (obs() !== '0) begin n_fail++; $display("FAIL reset_latch: got %h want 0", obs()); end
        n_checks++;
        if (stall_to_fe !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_to_fe); end
        bad = 0;
        for (int i = 0; i < 32; i++) if (dut.u_sb.cnt_q[i] !== 2'd0) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL reset_sb: %0d nonzero counters, want 0", bad); end
        reset = 1'b1;
    endtask

    task automatic test_decode();
        set_fe(32'hFFF1_0093);
        #1;
        tick();
        n_checks++;
        if ({de_valid, de_op, de_rd, de_wr_reg} !== {1'b1, OP_ALU_I, 5'd1, 1'b1}) begin
            n_fail++; $display("FAIL decode_ctl: got v=%b op=%0d rd=%0d wr=%b want v=1 op=%0d rd=1 wr=1",
                               de_valid, de_op, de_rd, de_wr_reg, OP_ALU_I);
        end
        n_checks++;
        if (de_imm !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL decode_imm: got %h want ffffffff", de_imm); end
        n_checks++;
        if (de_funct !== 4'b1000) begin n_fail++; $display("FAIL decode_funct: got %b want 1000", de_funct); end
        n_checks++;
        if (dut.u_sb.cnt_q[1] !== 2'd1) begin n_fail++; $display("FAIL decode_sb1: got %0d want 1", dut.u_sb.cnt_q[1]); end
    endtask

    task automatic test_raw();
        set_fe(32'h0010_81B3);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (stall_to_fe !== 1'b1) begin n_fail++; $display("FAIL raw_stall: cycle %0d got %b want 1", c, stall_to_fe); end
            tick();
            n_checks++;
            if (de_valid !== 1'b0) begin n_fail++; $display("FAIL raw_bubble: cycle %0d got %b want 0", c, de_valid); end
        end
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234_5678;
        #1;
`ifdef DE_WB_BYPASS_EN
        n_checks++;
        if (stall_to_fe !== 1'b0) begin n_fail++; $display("FAIL raw_wb_stall: got %b want 0", stall_to_fe); end
        tick();
        wb_we = 1'b0;
`else
        n_checks++;
        if (stall_to_fe !== 1'b1) begin n_fail++; $display("FAIL raw_wb_stall: got %b want 1", stall_to_fe); end
        tick();
        wb_we = 1'b0;
        n_checks++;
        if (de_valid !== 1'b0) begin n_fail++; $display("FAIL raw_wb_bubble: got %b want 0", de_valid); end
        #1;
        tick();
`endif
        n_checks++;
        if ({de_valid, de_rd, de_rs1_val, de_rs2_val} !== {1'b1, 5'd3, 32'h1234_5678, 32'h1234_5678}) begin
            n_fail++; $display("FAIL raw_issue: got v=%b rd=%0d rs1=%h rs2=%h want v=1 rd=3 rs1=12345678 rs2=12345678",
                               de_valid, de_rd, de_rs1_val, de_rs2_val);
        end
        n_checks++;
        if (dut.u_sb.cnt_q[1] !== 2'd0) begin n_fail++; $display("FAIL raw_sb1: got %0d want 0", dut.u_sb.cnt_q[1]); end
    endtask

    task automatic test_flush();
        set_fe(32'h0070_0293);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hA5A5_0003;
        #1;
        tick();
        wb_we = 1'b0;
        n_checks++;
        if ({de_valid, dut.u_sb.cnt_q[5]} !== {1'b1, 2'd1}) begin
            n_fail++; $display("FAIL flush_setup: got v=%b sb5=%0d want v=1 sb5=1", de_valid, dut.u_sb.cnt_q[5]);
        end
        set_fe(32'h0052_8333);
        br_mispred_agex = 1'b1;
        #1;
        n_checks++;
        if (stall_to_fe !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall_to_fe); end
        tick();
        br_mispred_agex = 1'b0;
        n_checks++;
        if ({de_valid, dut.u_sb.cnt_q[5], dut.u_sb.cnt_q[6]} !== {1'b0, 2'd0, 2'd0}) begin
            n_fail++; $display("FAIL flush_result: got v=%b sb5=%0d sb6=%0d want v=0 sb5=0 sb6=0",
                               de_valid, dut.u_sb.cnt_q[5], dut.u_sb.cnt_q[6]);
        end
    endtask

    task automatic test_simultaneous();
        set_fe(32'h0010_0393);
        #1;
        tick();
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_0777;
        #1;
        tick();
        wb_we = 1'b0;
        n_checks++;
        if (dut.u_sb.cnt_q[7] !== 2'd1) begin n_fail++; $display("FAIL simul_inc_dec: got %0d want 1", dut.u_sb.cnt_q[7]); end
        #1; tick();
        #1; tick();
        n_checks++;
        if (dut.u_sb.cnt_q[7] !== 2'd3) begin n_fail++; $display("FAIL simul_three: got %0d want 3", dut.u_sb.cnt_q[7]); end
        #1;
        n_checks++;
        if (stall_to_fe !== 1'b1) begin n_fail++; $display("FAIL simul_fourth_stall: got %b want 1", stall_to_fe); end
        tick();
        n_checks++;
        if ({de_valid, dut.u_sb.cnt_q[7]} !== {1'b0, 2'd3}) begin
            n_fail++; $display("FAIL simul_fourth: got v=%b sb7=%0d want v=0 sb7=3", de_valid, dut.u_sb.cnt_q[7]);
        end
        fe_valid = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd7;
        for (int k = 0; k < 3; k++) begin wb_data = $urandom; #1; tick(); end
        wb_we = 1'b0;
        n_checks++;
        if (dut.u_sb.cnt_q[7] !== 2'd0) begin n_fail++; $display("FAIL simul_drain: got %0d want 0", dut.u_sb.cnt_q[7]); end
    endtask

    task automatic test_x0();
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            set_fe(32'h0000_0033);
            #1;
            n_checks++;
            if (stall_to_fe !== 1'b0) begin n_fail++; $display("FAIL x0_stall: iter %0d got %b want 0", k, stall_to_fe); end
            tick();
            n_checks++;
            if ({de_valid, de_wr_reg, de_rs1_val, de_rs2_val, dut.u_sb.cnt_q[0]} !== {1'b1, 1'b0, 64'h0, 2'd0}) begin
                n_fail++; $display("FAIL x0_issue: iter %0d got v=%b wr=%b rs1=%h rs2=%h sb0=%0d want v=1 wr=0 rs1=0 rs2=0 sb0=0",
                                   k, de_valid, de_wr_reg, de_rs1_val, de_rs2_val, dut.u_sb.cnt_q[0]);
            end
        end
        wb_we = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_fe(32'h0010_0493);
        #1;
        tick();
        set_fe(32'h0094_8533);
        #1;
        n_checks++;
        if (stall_to_fe !== 1'b1) begin n_fail++; $display("FAIL rmid_stall: got %b want 1", stall_to_fe); end
        reset = 1'b0; br_mispred_agex = 1'b1;
        #1;
        n_checks++;
        if (stall_to_fe !== 1'b0) begin n_fail++; $display("FAIL rmid_stall_rst: got %b want 0", stall_to_fe); end
        tick();
        n_checks++;
        if ({obs(), dut.u_sb.cnt_q[9]} !== {239'h0, 2'd0}) begin
            n_fail++; $display("FAIL rmid_clear: got lat=%h sb9=%0d want 0", obs(), dut.u_sb.cnt_q[9]);
        end
        reset = 1'b1; br_mispred_agex = 1'b0;
    endtask

    task automatic test_random();
        bit hold;
        int r, bad, fl;
        hold = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!hold) begin
                set_fe({7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
                        5'($urandom_range(0, 7)), OPCS[$urandom_range(0, 9)]});
                fe_valid = ($urandom_range(0, 99) < 85);
            end
            br_mispred_agex = ($urandom_range(0, 99) < 8);
            r = $urandom_range(0, 7);
            fl = (br_mispred_agex && m_lat[238] && m_lat[224] && int'(m_lat[229:225]) == r) ? 1 : 0;
            wb_we   = ($urandom_range(0, 1) == 1) && (r == 0 || sb_m[r] - fl >= 1);
            wb_rd   = 5'(r);
            wb_data = $urandom;
            #1;
            hold = exp_stall();
            n_checks++;
            if (stall_to_fe !== hold) begin n_fail++; $display("FAIL rand_stall: cycle %0d got %b want %b", c, stall_to_fe, hold); end
            tick();
            n_checks++;
            if (obs() !== m_lat) begin n_fail++; $display("FAIL rand_latch: cycle %0d got %h want %h", c, obs(), m_lat); end
            bad = 0;
            for (int i = 0; i < 32; i++) if (dut.u_sb.cnt_q[i] !== 2'(sb_m[i])) bad++;
            n_checks++;
            if (bad != 0) begin n_fail++; $display("FAIL rand_sb: cycle %0d %0d counters differ from model", c, bad); end
        end
        wb_we = 1'b0; br_mispred_agex = 1'b0; fe_valid = 1'b0;
    endtask

    initial begin
        m_lat = '0;
        for (int i = 0; i < 32; i++) begin sb_m[i] = 0; rf_m[i] = '0; end
        test_reset();
        test_decode();
        test_raw();
        test_flush();
        test_simultaneous();
        test_x0();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
